// File: rtl/axis_i2c_cmd_packer_if.sv
// Stream and FIFO bundle for axis_i2c_cmd_packer.
//   s_axis_tdata/tvalid/tlast/tready : 8-bit AXI-Stream input (addr byte, then data bytes)
//   fifo_full                         : I2C master command FIFO full
//   fifo_wr_en/data/addr              : FIFO write strobe, data byte and 7-bit address
// slave  : the packer (consumes the stream, drives the FIFO write side)
// master : the environment (drives the stream and fifo_full)
interface axis_i2c_cmd_packer_if;
    logic [7:0] s_axis_tdata;
    logic       s_axis_tvalid;
    logic       s_axis_tlast;
    logic       s_axis_tready;
    logic       fifo_full;
    logic       fifo_wr_en;
    logic [7:0] data;
    logic [6:0] addr;

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, fifo_full,
        output s_axis_tready, fifo_wr_en, data, addr
    );

    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, fifo_full,
        input  s_axis_tready, fifo_wr_en, data, addr
    );
endinterface

// File: rtl/axis_i2c_cmd_packer.sv
// Unpacks AXI-Stream packets [addr, data0..dataN-1 (tlast)] into one I2C command FIFO
// write per data byte, tagged with the packet's 7-bit address.
//   clk, arst   : clock and asynchronous active-high reset
//   bus (slave) : stream input, fifo_full input, fifo_wr_en/data/addr outputs
//   busy        : high while not idle
//   pkt_cnt     : packets closed by tlast in DATA or DROP (wraps)
//   err_empty   : 1-cycle pulse after a packet with tlast on its address byte
//   err_trunc   : 1-cycle pulse after a packet that exceeded MAX_BURST data bytes
module axis_i2c_cmd_packer #(
    parameter int unsigned MAX_BURST = 16,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 arst,
    axis_i2c_cmd_packer_if.slave bus,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] pkt_cnt,
    output logic                 err_empty,
    output logic                 err_trunc
);

    localparam int unsigned BCW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [BCW-1:0] LAST_IDX = BCW'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [6:0]           addr_q, addr_d;
    logic [BCW-1:0]       cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d;
    logic                 err_empty_q, err_empty_d;
    logic                 err_trunc_q, err_trunc_d;
    logic                 tready;
    logic                 beat;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            pkt_cnt_q   <= '0;
            err_empty_q <= 1'b0;
            err_trunc_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            pkt_cnt_q   <= pkt_cnt_d;
            err_empty_q <= err_empty_d;
            err_trunc_q <= err_trunc_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        pkt_cnt_d   = pkt_cnt_q;
        err_empty_d = 1'b0;
        err_trunc_d = 1'b0;
        tready      = 1'b1;

        // Only DATA back-pressures; IDLE and DROP never write the FIFO.
        if (state_q == DATA) begin
            tready = ~bus.fifo_full;
        end
        beat = bus.s_axis_tvalid & tready;

        case (state_q)
            IDLE: begin
                if (beat) begin
                    addr_d = bus.s_axis_tdata[6:0];
                    cnt_d  = '0;
                    if (bus.s_axis_tlast) begin
                        err_empty_d = 1'b1;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (beat) begin
                    cnt_d = cnt_q + 1'b1;
                    // tlast wins over the burst limit: a full-length packet closes cleanly.
                    if (bus.s_axis_tlast) begin
                        state_d   = IDLE;
                        pkt_cnt_d = pkt_cnt_q + 1'b1;
                    end else if (cnt_q == LAST_IDX) begin
                        state_d = DROP;
                    end
                end
            end
            DROP: begin
                if (beat && bus.s_axis_tlast) begin
                    state_d     = IDLE;
                    pkt_cnt_d   = pkt_cnt_q + 1'b1;
                    err_trunc_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.s_axis_tready = tready;
    assign bus.fifo_wr_en    = (state_q == DATA) & bus.s_axis_tvalid & ~bus.fifo_full;
    assign bus.data          = bus.s_axis_tdata;
    assign bus.addr          = addr_q;
    assign busy              = (state_q != IDLE);
    assign pkt_cnt           = pkt_cnt_q;
    assign err_empty         = err_empty_q;
    assign err_trunc         = err_trunc_q;

endmodule

// File: tb/tb_axis_i2c_cmd_packer.sv
module tb_axis_i2c_cmd_packer;

    logic       clk;
    logic       arst;
    logic       busy;
    logic [1:0] pkt_cnt;
    logic       err_empty;
    logic       err_trunc;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned wr_seen = 0;
    logic        mon_en = 1'b0;
    logic [14:0] exp_q[$];

    axis_i2c_cmd_packer_if bus();

    axis_i2c_cmd_packer #(.MAX_BURST(4), .CNT_WIDTH(2)) dut (
        .clk       (clk),
        .arst      (arst),
        .bus       (bus),
        .busy      (busy),
        .pkt_cnt   (pkt_cnt),
        .err_empty (err_empty),
        .err_trunc (err_trunc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic       l;
        logic [7:0] d;
        logic       ff;
        logic       rdy;
        logic       wr;
        logic [6:0] a;
        logic       bsy;
        logic [1:0] pc;
        logic       ee;
        logic       et;
    } vec_t;

    vec_t tbl[28];

    function automatic vec_t mk(logic v, logic l, logic [7:0] d, logic ff, logic rdy, logic wr,
                                logic [6:0] a, logic bsy, logic [1:0] pc, logic ee, logic et);
        vec_t r;
        r.v = v; r.l = l; r.d = d; r.ff = ff; r.rdy = rdy; r.wr = wr;
        r.a = a; r.bsy = bsy; r.pc = pc; r.ee = ee; r.et = et;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic l, input logic [7:0] d, input logic ff);
        bus.s_axis_tvalid = v;
        bus.s_axis_tlast  = l;
        bus.s_axis_tdata  = d;
        bus.fifo_full     = ff;
    endtask

    // Apply one table row for one cycle; outputs checked mid-cycle (combinational ones
    // reflect this row's inputs, registered ones reflect earlier edges).
    task automatic apply(input int unsigned i, input vec_t r);
        drive(r.v, r.l, r.d, r.ff);
        @(negedge clk);
        chk($sformatf("row%0d_tready", i), 32'(bus.s_axis_tready), 32'(r.rdy));
        chk($sformatf("row%0d_wr_en", i), 32'(bus.fifo_wr_en), 32'(r.wr));
        chk($sformatf("row%0d_data", i), 32'(bus.data), 32'(r.d));
        chk($sformatf("row%0d_addr", i), 32'(bus.addr), 32'(r.a));
        chk($sformatf("row%0d_busy", i), 32'(busy), 32'(r.bsy));
        chk($sformatf("row%0d_pkt_cnt", i), 32'(pkt_cnt), 32'(r.pc));
        chk($sformatf("row%0d_err_empty", i), 32'(err_empty), 32'(r.ee));
        chk($sformatf("row%0d_err_trunc", i), 32'(err_trunc), 32'(r.et));
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic v, input logic l, input logic [7:0] d);
        drive(v, l, d, 1'b0);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard for the random-gap packet sequence.
    always @(negedge clk) begin
        if (mon_en && bus.fifo_wr_en) begin
            logic [14:0] e;
            wr_seen++;
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_write", 32'(1), 32'(0));
            end else begin
                e = exp_q.pop_front();
                chk("sb_addr", 32'(bus.addr), 32'(e[14:8]));
                chk("sb_data", 32'(bus.data), 32'(e[7:0]));
            end
        end
    end

    initial begin
        // Basic packet, empty packet, truncation, exact-MAX_BURST close, full on first data
        // cycle, tvalid gap in DATA, counter wrap (CNT_WIDTH=2).
        tbl[0]  = mk(1, 0, 8'h50, 0, 1, 0, 7'h00, 0, 2'd0, 0, 0);
        tbl[1]  = mk(1, 0, 8'hA1, 0, 1, 1, 7'h50, 1, 2'd0, 0, 0);
        tbl[2]  = mk(1, 0, 8'hB2, 0, 1, 1, 7'h50, 1, 2'd0, 0, 0);
        tbl[3]  = mk(1, 1, 8'hC3, 0, 1, 1, 7'h50, 1, 2'd0, 0, 0);
        tbl[4]  = mk(1, 1, 8'hD3, 0, 1, 0, 7'h50, 0, 2'd1, 0, 0);
        tbl[5]  = mk(0, 0, 8'h00, 0, 1, 0, 7'h53, 0, 2'd1, 1, 0);
        tbl[6]  = mk(1, 0, 8'h10, 0, 1, 0, 7'h53, 0, 2'd1, 0, 0);
        tbl[7]  = mk(1, 0, 8'h00, 0, 1, 1, 7'h10, 1, 2'd1, 0, 0);
        tbl[8]  = mk(1, 0, 8'h01, 0, 1, 1, 7'h10, 1, 2'd1, 0, 0);
        tbl[9]  = mk(1, 0, 8'h02, 0, 1, 1, 7'h10, 1, 2'd1, 0, 0);
        tbl[10] = mk(1, 0, 8'h03, 0, 1, 1, 7'h10, 1, 2'd1, 0, 0);
        tbl[11] = mk(1, 0, 8'h04, 0, 1, 0, 7'h10, 1, 2'd1, 0, 0);
        tbl[12] = mk(1, 1, 8'h05, 0, 1, 0, 7'h10, 1, 2'd1, 0, 0);
        tbl[13] = mk(0, 0, 8'h00, 0, 1, 0, 7'h10, 0, 2'd2, 0, 1);
        tbl[14] = mk(1, 0, 8'h85, 0, 1, 0, 7'h10, 0, 2'd2, 0, 0);
        tbl[15] = mk(1, 0, 8'h11, 0, 1, 1, 7'h05, 1, 2'd2, 0, 0);
        tbl[16] = mk(1, 0, 8'h22, 0, 1, 1, 7'h05, 1, 2'd2, 0, 0);
        tbl[17] = mk(1, 0, 8'h33, 0, 1, 1, 7'h05, 1, 2'd2, 0, 0);
        tbl[18] = mk(1, 1, 8'h44, 0, 1, 1, 7'h05, 1, 2'd2, 0, 0);
        tbl[19] = mk(0, 0, 8'h00, 0, 1, 0, 7'h05, 0, 2'd3, 0, 0);
        tbl[20] = mk(1, 0, 8'h2C, 1, 1, 0, 7'h05, 0, 2'd3, 0, 0);
        tbl[21] = mk(1, 0, 8'h9A, 1, 0, 0, 7'h2C, 1, 2'd3, 0, 0);
        tbl[22] = mk(1, 1, 8'h9A, 0, 1, 1, 7'h2C, 1, 2'd3, 0, 0);
        tbl[23] = mk(0, 0, 8'h00, 0, 1, 0, 7'h2C, 0, 2'd0, 0, 0);
        tbl[24] = mk(1, 0, 8'h01, 0, 1, 0, 7'h2C, 0, 2'd0, 0, 0);
        tbl[25] = mk(0, 0, 8'h00, 0, 1, 0, 7'h01, 1, 2'd0, 0, 0);
        tbl[26] = mk(1, 1, 8'h5A, 0, 1, 1, 7'h01, 1, 2'd0, 0, 0);
        tbl[27] = mk(0, 0, 8'h00, 0, 1, 0, 7'h01, 0, 2'd1, 0, 0);

        arst = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_pkt_cnt", 32'(pkt_cnt), 32'(0));
        chk("rst_addr", 32'(bus.addr), 32'(0));
        chk("rst_wr_en", 32'(bus.fifo_wr_en), 32'(0));
        chk("rst_err_empty", 32'(err_empty), 32'(0));
        chk("rst_err_trunc", 32'(err_trunc), 32'(0));
        @(negedge clk);
        arst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 28; i++) begin
            apply(i, tbl[i]);
        end

        // fifo_full held for 10 cycles with a data byte pending.
        put(1'b1, 1'b0, 8'h33);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, 8'h77, 1'b1);
            @(negedge clk);
            chk($sformatf("stall%0d_tready", i), 32'(bus.s_axis_tready), 32'(0));
            chk($sformatf("stall%0d_wr_en", i), 32'(bus.fifo_wr_en), 32'(0));
            @(posedge clk);
            #1;
        end
        drive(1'b1, 1'b0, 8'h77, 1'b0);
        @(negedge clk);
        chk("unstall_wr_en", 32'(bus.fifo_wr_en), 32'(1));
        chk("unstall_data", 32'(bus.data), 32'h77);
        chk("unstall_addr", 32'(bus.addr), 32'h33);
        @(posedge clk);
        #1;
        drive(1'b1, 1'b1, 8'h78, 1'b0);
        @(negedge clk);
        chk("resume_wr_en", 32'(bus.fifo_wr_en), 32'(1));
        chk("resume_data", 32'(bus.data), 32'h78);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        chk("stall_pkt_cnt", 32'(pkt_cnt), 32'(2));

        // Reset in the middle of a packet.
        put(1'b1, 1'b0, 8'h40);
        put(1'b1, 1'b0, 8'h01);
        put(1'b1, 1'b0, 8'h02);
        drive(1'b1, 1'b0, 8'h03, 1'b0);
        arst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'(0));
        chk("arst_pkt_cnt", 32'(pkt_cnt), 32'(0));
        chk("arst_addr", 32'(bus.addr), 32'(0));
        chk("arst_wr_en", 32'(bus.fifo_wr_en), 32'(0));
        chk("arst_tready", 32'(bus.s_axis_tready), 32'(1));
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        arst = 1'b0;
        @(posedge clk);
        #1;
        put(1'b1, 1'b0, 8'h2A);
        drive(1'b1, 1'b0, 8'h5C, 1'b0);
        @(negedge clk);
        chk("post_rst_wr_en", 32'(bus.fifo_wr_en), 32'(1));
        chk("post_rst_addr", 32'(bus.addr), 32'h2A);
        chk("post_rst_data", 32'(bus.data), 32'h5C);
        @(posedge clk);
        #1;
        put(1'b1, 1'b1, 8'h6D);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        chk("post_rst_pkt_cnt", 32'(pkt_cnt), 32'(1));

        // Five 2-byte packets with random idle gaps; pkt_cnt wraps at 4.
        arst = 1'b1;
        #2;
        arst = 1'b0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        for (int p = 0; p < 5; p++) begin
            logic [7:0] a;
            logic [7:0] d;
            a = 8'($urandom_range(0, 255));
            d = 8'($urandom_range(0, 255));
            repeat ($urandom_range(0, 2)) put(1'b0, 1'b0, 8'h00);
            put(1'b1, 1'b0, a);
            repeat ($urandom_range(0, 2)) put(1'b0, 1'b0, 8'h00);
            exp_q.push_back({a[6:0], d});
            put(1'b1, 1'b1, d);
            drive(1'b0, 1'b0, 8'h00, 1'b0);
            chk($sformatf("burst_pkt%0d_cnt", p), 32'(pkt_cnt), 32'((p + 1) % 4));
        end
        repeat (2) put(1'b0, 1'b0, 8'h00);
        mon_en = 1'b0;
        chk("burst_write_count", 32'(wr_seen), 32'(5));
        chk("burst_sb_drained", 32'(exp_q.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
